// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: fixed-latency, fully pipelined word fetch for the core,
// with an independent host load port. Core writes are rejected and flagged.
module inst_mem_responder #(
   parameter int                    INST_WIDTH      = 32,
   parameter int                    INST_ADDR_WIDTH = 32,
   parameter int                    MEM_ADDR_WIDTH  = 7,
   parameter int                    READ_LATENCY    = 1,
   parameter logic [INST_WIDTH-1:0] OOR_FILL        = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       inst_we_core2mem,
   input  logic                       inst_request_core2mem,
   input  logic [INST_ADDR_WIDTH-1:0] inst_addr_core2mem,
   output logic                       inst_valid_mem2core,
   output logic [INST_WIDTH-1:0]      inst_mem2core,
   input  logic                       load_en,
   input  logic [MEM_ADDR_WIDTH-1:0]  load_addr,
   input  logic [INST_WIDTH-1:0]      load_data,
   output logic                       err_illegal_write,
   output logic                       err_out_of_range
);

   localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

   if (MEM_ADDR_WIDTH > INST_ADDR_WIDTH) begin : g_bad_addr_width
      $error("inst_mem_responder: MEM_ADDR_WIDTH must not exceed INST_ADDR_WIDTH");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("inst_mem_responder: READ_LATENCY must be in 1..4");
   end

   logic [INST_WIDTH-1:0]     mem_q [DEPTH];

   logic                      rd_accept;
   logic                      rd_oor;
   logic                      wr_illegal;
   logic [MEM_ADDR_WIDTH-1:0] rd_idx;

   logic [READ_LATENCY-1:0]   pipe_valid_q;
   logic [READ_LATENCY-1:0]   pipe_valid_d;
   logic [INST_WIDTH-1:0]     pipe_data_q [READ_LATENCY];
   logic [INST_WIDTH-1:0]     pipe_data_d [READ_LATENCY];

   logic                      err_illegal_write_q;
   logic                      err_illegal_write_d;
   logic                      err_out_of_range_q;
   logic                      err_out_of_range_d;

   // Range check uses the full core address; indexing uses only the low bits.
   always_comb begin
      rd_oor     = |(inst_addr_core2mem >> MEM_ADDR_WIDTH);
      rd_idx     = inst_addr_core2mem[MEM_ADDR_WIDTH-1:0];
      rd_accept  = inst_request_core2mem & ~inst_we_core2mem;
      wr_illegal = inst_request_core2mem &  inst_we_core2mem;
   end

   // Data in each stage only advances alongside a valid token, so the output
   // word holds the last delivered instruction while no response is due.
   always_comb begin
      pipe_valid_d = '0;
      pipe_data_d  = pipe_data_q;

      pipe_valid_d[0] = rd_accept;
      if (rd_accept) begin
         pipe_data_d[0] = rd_oor ? OOR_FILL : mem_q[rd_idx];
      end

      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_valid_d[i] = pipe_valid_q[i-1];
         if (pipe_valid_q[i-1]) begin
            pipe_data_d[i] = pipe_data_q[i-1];
         end
      end
   end

   always_comb begin
      err_illegal_write_d = err_illegal_write_q | wr_illegal;
      err_out_of_range_d  = err_out_of_range_q  | (rd_accept & rd_oor);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe_valid_q        <= '0;
         err_illegal_write_q <= 1'b0;
         err_out_of_range_q  <= 1'b0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_data_q[i] <= '0;
         end
      end else begin
         pipe_valid_q        <= pipe_valid_d;
         err_illegal_write_q <= err_illegal_write_d;
         err_out_of_range_q  <= err_out_of_range_d;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_data_q[i] <= pipe_data_d[i];
         end
      end
   end

   // Storage has no reset and keeps loading while the rest of the block is held in reset.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem_q[load_addr] <= load_data;
      end
   end

   assign inst_valid_mem2core = pipe_valid_q[READ_LATENCY-1];
   assign inst_mem2core       = pipe_data_q[READ_LATENCY-1];
   assign err_illegal_write   = err_illegal_write_q;
   assign err_out_of_range    = err_out_of_range_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench: two responders (latency 1 and 3) share stimulus; expected
// responses are queued at drive time and checked when each DUT answers.
module tb_inst_mem_responder;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic        ld;
   logic [6:0]  la;
   logic [31:0] ldd;

   logic [1:0]       v;
   logic [1:0][31:0] d;
   logic [1:0]       ei;
   logic [1:0]       eo;

   int          checks   = 0;
   int          failures = 0;
   int          ecount   = 0;
   logic        rst_seen = 1'b0;
   logic        exp_ill  = 1'b0;
   logic        exp_oor  = 1'b0;
   int          lat [2]  = '{1, 3};
   logic [31:0] last [2] = '{32'h0, 32'h0};
   logic [31:0] model [128];
   exp_t        exp_q [2][$];

   always #5 clk = ~clk;

   inst_mem_responder #(.READ_LATENCY(1)) u_dut1 (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .inst_we_core2mem      (we),
      .inst_request_core2mem (req),
      .inst_addr_core2mem    (addr),
      .inst_valid_mem2core   (v[0]),
      .inst_mem2core         (d[0]),
      .load_en               (ld),
      .load_addr             (la),
      .load_data             (ldd),
      .err_illegal_write     (ei[0]),
      .err_out_of_range      (eo[0])
   );

   inst_mem_responder #(.READ_LATENCY(3)) u_dut3 (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .inst_we_core2mem      (we),
      .inst_request_core2mem (req),
      .inst_addr_core2mem    (addr),
      .inst_valid_mem2core   (v[1]),
      .inst_mem2core         (d[1]),
      .load_en               (ld),
      .load_addr             (la),
      .load_data             (ldd),
      .err_illegal_write     (ei[1]),
      .err_out_of_range      (eo[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after an edge and are sampled by the next edge.
   task automatic drive(input logic r, input logic rq, input logic w, input logic [31:0] a,
                        input logic l, input logic [6:0] lad, input logic [31:0] ldat);
      @(posedge clk);
      #1;
      rst_n = r;
      req   = rq;
      we    = w;
      addr  = a;
      ld    = l;
      la    = lad;
      ldd   = ldat;
      if (r && rq && !w) begin
         for (int i = 0; i < 2; i++) begin
            exp_t e;
            e.due  = ecount + lat[i];
            e.data = (a[31:7] != 25'd0) ? 32'h00000013 : model[a[6:0]];
            exp_q[i].push_back(e);
         end
      end
      if (l) model[lad] = ldat;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 32'h0);
   endtask

   task automatic rd(input logic [31:0] a);
      drive(1'b1, 1'b1, 1'b0, a, 1'b0, 7'h0, 32'h0);
   endtask

   always @(posedge clk) begin
      ecount   <= ecount + 1;
      rst_seen <= rst_n;
      if (!rst_n) begin
         exp_ill <= 1'b0;
         exp_oor <= 1'b0;
      end else if (req) begin
         if (we) exp_ill <= 1'b1;
         else if (addr[31:7] != 25'd0) exp_oor <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (ecount > 0) begin
         for (int i = 0; i < 2; i++) begin
            string p;
            p = (i == 0) ? "L1" : "L3";
            if (!rst_seen) begin
               chk({p, "_rst_valid"}, v[i], 0);
               chk({p, "_rst_data"}, d[i], 0);
               chk({p, "_rst_err_ill"}, ei[i], 0);
               chk({p, "_rst_err_oor"}, eo[i], 0);
               exp_q[i].delete();
               last[i] = 32'h0;
            end else begin
               if (v[i]) begin
                  if (exp_q[i].size() == 0) begin
                     chk({p, "_valid_spurious"}, v[i], 0);
                  end else begin
                     exp_t e;
                     e = exp_q[i].pop_front();
                     chk({p, "_resp_cycle"}, ecount, e.due);
                     chk({p, "_resp_data"}, d[i], e.data);
                     last[i] = e.data;
                  end
               end else begin
                  if (exp_q[i].size() != 0 && exp_q[i][0].due <= ecount) begin
                     chk({p, "_valid_missing"}, v[i], 1);
                     void'(exp_q[i].pop_front());
                  end
                  chk({p, "_hold_data"}, d[i], last[i]);
               end
               chk({p, "_err_ill"}, ei[i], exp_ill);
               chk({p, "_err_oor"}, eo[i], exp_oor);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0;
      ld = 1'b0; la = 7'h0; ldd = 32'h0;

      // Program loaded while the block is held in reset.
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 7'd0, 32'h00500093);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 7'd1, 32'h00A00113);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 7'd2, 32'h002081B3);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 7'd3, 32'h00000013);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 7'd4, 32'h44444444);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 7'd5, 32'h11111111);
      idle(2);

      rd(32'd2);
      idle(4);

      for (int a = 0; a < 4; a++) rd(a);
      idle(5);

      // Same-edge load and read of word 5: old word first, new word next.
      drive(1'b1, 1'b1, 1'b0, 32'd5, 1'b1, 7'd5, 32'hDEADBEEF);
      rd(32'd5);
      idle(4);

      rd(32'h00000080);
      rd(32'h00000001);
      rd(32'hFFFFFFFF);
      idle(4);

      drive(1'b1, 1'b1, 1'b1, 32'd4, 1'b0, 7'h0, 32'h0);
      rd(32'd4);
      idle(4);

      // Reads in flight when reset hits; a load during reset still lands.
      rd(32'd0);
      rd(32'd1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 7'd6, 32'h66666666);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 32'h0);
      idle(3);
      rd(32'd0);
      rd(32'd6);
      idle(1);

      for (int k = 0; k < 20 && (exp_q[0].size() + exp_q[1].size()) != 0; k++) idle(1);
      idle(2);
      chk("drain_empty", exp_q[0].size() + exp_q[1].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Instruction-memory responder: the memory side of the `*_core2mem` / `*_mem2core` instruction fetch interface.
- Serves word-addressed fetch requests from the five-stage core with a fixed, parameterised read latency. Fully pipelined: one request accepted per cycle.
- A separate host load port preloads the program before and during `start`.
- The core has no write path into instruction memory. Core write requests are rejected and flagged.

Parameters:
- INST_WIDTH, 32, instruction/data word width.
- INST_ADDR_WIDTH, 32, width of the core-side word address.
- MEM_ADDR_WIDTH, 7, log2 of storage depth (128 words); must be ≤ INST_ADDR_WIDTH.
- READ_LATENCY, 1, cycles from request to valid response; legal range 1..4.
- OOR_FILL, 32'h00000013, word returned for out-of-range reads (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- inst_we_core2mem  in  1  core write-request qualifier; writes are illegal.
- inst_request_core2mem  in  1  fetch request strobe, sampled each rising edge.
- inst_addr_core2mem  in  INST_ADDR_WIDTH  word address of the fetch (byte PC >> 2).
- inst_valid_mem2core  out  1  response valid, one cycle per accepted read.
- inst_mem2core  out  INST_WIDTH  response instruction word.
- load_en  in  1  host write strobe.
- load_addr  in  MEM_ADDR_WIDTH  host word address.
- load_data  in  INST_WIDTH  host write data.
- err_illegal_write  out  1  sticky: a core request arrived with we=1.
- err_out_of_range  out  1  sticky: a core read addressed beyond the storage depth.

Behaviour:
- Storage is 2^MEM_ADDR_WIDTH words. Contents are not cleared by reset; they are retained across reset.
- Load port: when load_en=1 at a rising edge, mem[load_addr] <= load_data. It is independent of core traffic and never stalls.
- Accepted read: request=1 and we=0 at edge k.
  - inst_valid_mem2core is high for exactly the one cycle following edge k+READ_LATENCY-1. At READ_LATENCY=1 valid is registered and appears in the cycle right after the request cycle.
  - Responses return in request order, one per accepted read. No back-pressure exists and no request is dropped.
- Throughput: back-to-back requests on consecutive cycles give back-to-back valid cycles with the same latency.
- Read-data pipeline: a shift pipe of READ_LATENCY stages carries {valid, data}. Storage is read in stage 1; later stages are pure delay.
- Same-cycle load and read to the same address: the read returns the OLD word (read-before-write). The new word is visible to reads issued at edge k+1 or later.
- Out-of-range read: a read is out of range when any address bit at or above MEM_ADDR_WIDTH is nonzero.
  - It is still acknowledged with normal latency.
  - inst_mem2core = OOR_FILL.
  - err_out_of_range is set 1 at edge k.
- Illegal write: request=1 and we=1.
  - No storage update and no valid response.
  - err_illegal_write is set 1 at edge k.
- request=0: we and addr are ignored.
- inst_mem2core holds the last delivered word while valid=0.
- Reset (rst_n=0 at an edge):
  - inst_valid_mem2core=0, inst_mem2core=0, both err flags=0.
  - The entire response pipe is flushed: in-flight responses are discarded, never delivered.
  - Requests sampled during reset are ignored.
  - A load_en during reset still writes storage.
- Error flags clear only on reset.
- Width rules: the address is truncated to MEM_ADDR_WIDTH bits for indexing only after the range check.

Test Plan:
- Load mem[0..3]=32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013. READ_LATENCY=1. Request addr 2 at edge 10 -> valid=1 with 32'h002081B3 in the cycle after edge 10 only. No errors.
- READ_LATENCY=3. Requests addr 0,1,2,3 on four consecutive edges 20..23 -> valid high after edges 22..25, data in order 00500093, 00A00113, 002081B3, 00000013. Valid low before and after.
- Same edge: load_en with load_addr=5, load_data=32'hDEADBEEF, and read addr 5 (old 32'h11111111) -> returns 32'h11111111. Read at the next edge -> 32'hDEADBEEF.
- Read addr 32'h00000080 (depth 128) -> valid with 32'h00000013 after latency. err_out_of_range=1 and stays 1.
- Request with we=1, addr 4 -> no valid pulse, mem[4] unchanged on a later read, err_illegal_write=1.
- READ_LATENCY=3. Reads issued at edges 30, 31; rst_n=0 at edge 32 -> no valid pulses ever appear, outputs and flags 0. After reset release, a read of addr 0 returns the preloaded 32'h00500093 (contents retained).
